rob_commit_unit: RTL and testbench
==================================

# rob_commit_unit

In-order retirement stage that sits directly downstream of the reorder-buffer circular queue. Each cycle it inspects the entry at the queue head and, when that entry is complete, pops it. A popped entry updates the architectural rename map and returns the superseded physical register to the free-list queue. On a committed mispredict it issues a one-cycle pipeline flush plus a redirect PC; on a committed halt it stops retirement permanently until reset.

## Interface
Parameters:
- ARCH_W, 5, architectural register index width
- PHYS_W, 6, physical register tag width
- PC_W, 32, redirect target width
- ENTRY_W, 4+ARCH_W+2*PHYS_W+PC_W (53), ROB entry width; derived, not overridden

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- robEntry_IN  in  ENTRY_W  entry at ROB queue head (queue data_OUT)
- robEmpty_IN  in  1  ROB queue empty flag
- robPop_OUT  out  1  pop request to ROB queue
- freeFull_IN  in  1  free-list queue full flag
- freePush_OUT  out  1  push request to free-list queue
- freeData_OUT  out  PHYS_W  physical tag being freed
- archWrEn_OUT  out  1  architectural map write enable
- archWrIdx_OUT  out  ARCH_W  architectural register written
- archWrData_OUT  out  PHYS_W  new physical tag for that register
- flush_OUT  out  1  pipeline/queue flush pulse
- redirectPC_OUT  out  PC_W  fetch redirect target; meaningful while flush_OUT=1
- halted_OUT  out  1  retirement stopped by halt
- commitCount_OUT  out  32  entries retired since reset
- stallCount_OUT  out  32  cycles a done head was blocked by freeFull_IN

## Operation
Entry layout, MSB to LSB: done, mispred, halt, regWrite, archDest[ARCH_W], newPhys[PHYS_W], oldPhys[PHYS_W], target[PC_W].

States:
- RUN
- FLUSH
- HALTED

RUN behaviour:
- Head is committable when robEmpty_IN=0 and done=1.
- Committable with regWrite=1 and freeFull_IN=1: stall. No pop, no writes, stallCount_OUT+1.
- Otherwise a committable head commits:
  - robPop_OUT=1; commitCount_OUT+1.
  - If regWrite=1 and halt=0: archWrEn_OUT=1 with archDest/newPhys; freePush_OUT=1 with oldPhys.
  - halt=1: next state HALTED; regWrite is ignored; halt takes priority over mispred.
  - Else mispred=1: redirect register loads target; next state FLUSH.
- Not committable: outputs idle, stay in RUN.

FLUSH and HALTED:
- FLUSH lasts exactly one cycle: flush_OUT=1, no pop or writes; then RUN.
- HALTED: halted_OUT=1; all pop and write outputs 0; exits only on reset.

General rules:
- robPop_OUT, freePush_OUT and archWr* are combinational from state and inputs. They are valid in the same cycle the queues sample them.
- flush_OUT, redirectPC_OUT, halted_OUT and both counters are registered.
- Counters are 32-bit unsigned and wrap 0xFFFFFFFF -> 0.
- At most one commit per cycle.

## Timing
- Reset (asynchronous, immediate):
  - State=RUN; flush_OUT=0, redirectPC_OUT=0, halted_OUT=0, both counters 0.
  - Combinational outputs are 0 because the RUN gating requires reset=1.
- Reset asserted mid-FLUSH or in HALTED: flush_OUT/halted_OUT drop immediately. First commit is possible in the first cycle after deassertion.
- Commit latency: a head that is done in cycle N pops at the N/N+1 edge. The next head can commit in cycle N+1.
- Mispredict commit in cycle N:
  - flush_OUT=1 and redirectPC_OUT=target throughout cycle N+1.
  - flush_OUT feeds the ROB queue flush_IN, clearing it at the N+1/N+2 edge.
  - Normal commit resumes in N+2.
- Halt commit in cycle N: halted_OUT=1 from cycle N+1.
- Empty and done=1 on stale data: no commit (robEmpty_IN dominates).
- freeFull_IN only blocks regWrite=1 entries. regWrite=0 entries commit while the free list is full.
- Free-list full and ROB empty together: no stall counted.

## Test plan
- Reset, then push 3 done regWrite entries (archDest 1,2,3; newPhys 0x21,0x22,0x23; oldPhys 1,2,3) -> pops on 3 consecutive cycles, archWr (1,0x21),(2,0x22),(3,0x23), free pushes 1,2,3, commitCount_OUT=3.
- Head done=0 for 4 cycles, then done=1 -> no pop for 4 cycles, pop in 5th, stallCount_OUT stays 0.
- freeFull_IN=1 with regWrite head for 3 cycles, then 0 -> stallCount_OUT=3, single pop on release cycle. Repeat with regWrite=0 head -> immediate pop despite full.
- Mispredict entry target 0x0000_1000 followed by 2 younger entries -> pop in N, flush_OUT=1/redirectPC_OUT=0x1000 in N+1 only, younger entries never committed, commitCount_OUT+1.
- Halt entry with mispred=1, regWrite=1 -> pop, no archWr/freePush, no flush, halted_OUT=1 from N+1; further done entries never pop; asserting reset clears halted_OUT immediately and commits resume.
- Preload commitCount_OUT near wrap via 2^32-1 commits (or forced) -> next commit yields 0.

Source files
------------

// File: rtl/rob_commit_unit.sv
// rob_commit_unit: in-order retirement stage behind the ROB queue.
// Pops a completed head entry each cycle. A popped entry updates the architectural
// rename map and frees its superseded physical tag. A mispredict produces a
// one-cycle flush with a redirect PC. A halt stops retirement until reset.
module rob_commit_unit #(
  parameter int ARCH_W = 5,
  parameter int PHYS_W = 6,
  parameter int PC_W = 32,
  localparam int ENTRY_W = 4 + ARCH_W + 2 * PHYS_W + PC_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ENTRY_W-1:0] robEntry_IN,
  input  logic               robEmpty_IN,
  output logic               robPop_OUT,
  input  logic               freeFull_IN,
  output logic               freePush_OUT,
  output logic [PHYS_W-1:0]  freeData_OUT,
  output logic               archWrEn_OUT,
  output logic [ARCH_W-1:0]  archWrIdx_OUT,
  output logic [PHYS_W-1:0]  archWrData_OUT,
  output logic               flush_OUT,
  output logic [PC_W-1:0]    redirectPC_OUT,
  output logic               halted_OUT,
  output logic [31:0]        commitCount_OUT,
  output logic [31:0]        stallCount_OUT
);

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  state_t stateReg, stateNext;

  logic              flushReg;
  logic              haltedReg;
  logic [PC_W-1:0]   redirectReg;
  logic [31:0]       commitCountReg;
  logic [31:0]       stallCountReg;

  logic              loadRedirect;
  logic              doStall;

  // Head entry fields
  logic              entDone, entMispred, entHalt, entRegWrite;
  logic [ARCH_W-1:0] entArchDest;
  logic [PHYS_W-1:0] entNewPhys, entOldPhys;
  logic [PC_W-1:0]   entTarget;
  logic              entWritesReg;

  assign entDone     = robEntry_IN[ENTRY_W-1];
  assign entMispred  = robEntry_IN[ENTRY_W-2];
  assign entHalt     = robEntry_IN[ENTRY_W-3];
  assign entRegWrite = robEntry_IN[ENTRY_W-4];
  assign entArchDest = robEntry_IN[PC_W + 2 * PHYS_W +: ARCH_W];
  assign entNewPhys  = robEntry_IN[PC_W + PHYS_W +: PHYS_W];
  assign entOldPhys  = robEntry_IN[PC_W +: PHYS_W];
  assign entTarget   = robEntry_IN[PC_W-1:0];

  // A halt ignores regWrite entirely, so it never writes and never waits on the free list.
  assign entWritesReg = entRegWrite & ~entHalt;

  // Next-state and combinational pop/write outputs. These are gated by reset so
  // they stay quiet while reset is asserted.
  always_comb begin
    stateNext      = stateReg;
    robPop_OUT     = 1'b0;
    freePush_OUT   = 1'b0;
    freeData_OUT   = entOldPhys;
    archWrEn_OUT   = 1'b0;
    archWrIdx_OUT  = entArchDest;
    archWrData_OUT = entNewPhys;
    loadRedirect   = 1'b0;
    doStall        = 1'b0;
    case (stateReg)
      RUN: begin
        if (reset && !robEmpty_IN && entDone) begin
          if (entWritesReg && freeFull_IN) begin
            doStall = 1'b1;
          end else begin
            robPop_OUT = 1'b1;
            if (entHalt) begin
              stateNext = HALTED;
            end else begin
              if (entRegWrite) begin
                archWrEn_OUT = 1'b1;
                freePush_OUT = 1'b1;
              end
              if (entMispred) begin
                loadRedirect = 1'b1;
                stateNext    = FLUSH;
              end
            end
          end
        end
      end
      FLUSH:   stateNext = RUN;
      HALTED:  stateNext = HALTED;
      default: stateNext = RUN;
    endcase
  end

  // State, registered status outputs and the retirement counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg       <= RUN;
      flushReg       <= 1'b0;
      haltedReg      <= 1'b0;
      redirectReg    <= '0;
      commitCountReg <= '0;
      stallCountReg  <= '0;
    end else begin
      stateReg  <= stateNext;
      flushReg  <= (stateNext == FLUSH);
      haltedReg <= (stateNext == HALTED);
      if (loadRedirect) begin
        redirectReg <= entTarget;
      end
      if (robPop_OUT) begin
        commitCountReg <= commitCountReg + 32'd1;
      end
      if (doStall) begin
        stallCountReg <= stallCountReg + 32'd1;
      end
    end
  end

  assign flush_OUT       = flushReg;
  assign redirectPC_OUT  = redirectReg;
  assign halted_OUT      = haltedReg;
  assign commitCount_OUT = commitCountReg;
  assign stallCount_OUT  = stallCountReg;

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb_rob_commit_unit: scoreboard bench for the ROB commit stage.
// The main process models the ROB queue and issues directed entries, pushing the
// expected commit / flush responses; a monitor pops and compares them whenever
// the DUT pops the ROB or raises flush.
module tb_rob_commit_unit;

  localparam int ARCH_W = 5;
  localparam int PHYS_W = 6;
  localparam int PC_W = 32;
  localparam int ENTRY_W = 4 + ARCH_W + 2 * PHYS_W + PC_W;

  typedef struct packed {
    logic              wrEn;
    logic [ARCH_W-1:0] idx;
    logic [PHYS_W-1:0] data;
    logic              push;
    logic [PHYS_W-1:0] free;
  } commit_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [ENTRY_W-1:0] robEntry = '0;
  logic               robEmpty = 1'b1;
  logic               robPop;
  logic               freeFull = 1'b0;
  logic               freePush;
  logic [PHYS_W-1:0]  freeData;
  logic               archWrEn;
  logic [ARCH_W-1:0]  archWrIdx;
  logic [PHYS_W-1:0]  archWrData;
  logic               flush;
  logic [PC_W-1:0]    redirectPC;
  logic               halted;
  logic [31:0]        commitCount;
  logic [31:0]        stallCount;

  int checks = 0;
  int failures = 0;

  logic [ENTRY_W-1:0] robQ[$];
  commit_t            expQ[$];
  logic [PC_W-1:0]    flushQ[$];
  logic               lastFlush;
  logic [ENTRY_W-1:0] tmpEntry;

  rob_commit_unit #(.ARCH_W(ARCH_W), .PHYS_W(PHYS_W), .PC_W(PC_W)) dut (
    .clk(clk),
    .reset(reset),
    .robEntry_IN(robEntry),
    .robEmpty_IN(robEmpty),
    .robPop_OUT(robPop),
    .freeFull_IN(freeFull),
    .freePush_OUT(freePush),
    .freeData_OUT(freeData),
    .archWrEn_OUT(archWrEn),
    .archWrIdx_OUT(archWrIdx),
    .archWrData_OUT(archWrData),
    .flush_OUT(flush),
    .redirectPC_OUT(redirectPC),
    .halted_OUT(halted),
    .commitCount_OUT(commitCount),
    .stallCount_OUT(stallCount)
  );

  always #5 clk = ~clk;

  function automatic logic [ENTRY_W-1:0] mk(input logic d, input logic m, input logic h,
      input logic w, input logic [ARCH_W-1:0] a, input logic [PHYS_W-1:0] np,
      input logic [PHYS_W-1:0] op, input logic [PC_W-1:0] t);
    return {d, m, h, w, a, np, op, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic expectCommit(input logic w, input logic [ARCH_W-1:0] idx,
      input logic [PHYS_W-1:0] data, input logic p, input logic [PHYS_W-1:0] fr);
    commit_t c;
    c.wrEn = w; c.idx = idx; c.data = data; c.push = p; c.free = fr;
    expQ.push_back(c);
  endtask

  // One clock of the ROB queue model: present head at the falling edge, then
  // apply the pop or flush the DUT requested at the rising edge.
  task automatic cycle();
    logic sawPop, sawFlush;
    @(negedge clk);
    robEmpty = (robQ.size() == 0);
    if (robQ.size() != 0) robEntry = robQ[0];
    #1;
    sawPop = robPop;
    sawFlush = flush;
    lastFlush = sawFlush;
    @(posedge clk);
    #1;
    if (sawFlush) robQ.delete();
    else if (sawPop) void'(robQ.pop_front());
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: compare every pop and every flush cycle against the scoreboard.
  always @(negedge clk) begin
    commit_t e;
    #2;
    if (robPop) begin
      if (expQ.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        check("commit_archWrEn", 32'(archWrEn), 32'(e.wrEn));
        check("commit_freePush", 32'(freePush), 32'(e.push));
        if (e.wrEn) begin
          check("commit_archWrIdx", 32'(archWrIdx), 32'(e.idx));
          check("commit_archWrData", 32'(archWrData), 32'(e.data));
        end
        if (e.push) check("commit_freeData", 32'(freeData), 32'(e.free));
      end
    end else begin
      check("idle_no_writes", 32'({archWrEn, freePush}), 32'd0);
    end
    if (flush) begin
      if (flushQ.size() == 0) check("unexpected_flush", 32'd1, 32'd0);
      else check("flush_redirectPC", redirectPC, flushQ.pop_front());
    end
  end

  initial begin
    // Reset: outputs quiet even with a done head presented.
    robEmpty = 1'b0;
    robEntry = mk(1, 0, 0, 1, 5'd1, 6'h21, 6'd1, 32'h0);
    #3;
    check("rst_pop", 32'(robPop), 32'd0);
    check("rst_archWrEn", 32'(archWrEn), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_redirect", redirectPC, 32'd0);
    check("rst_commitCount", commitCount, 32'd0);
    check("rst_stallCount", stallCount, 32'd0);
    robEmpty = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Three back-to-back register-writing commits.
    for (int i = 1; i <= 3; i++) begin
      robQ.push_back(mk(1, 0, 0, 1, 5'(i), 6'(32 + i), 6'(i), 32'h0));
      expectCommit(1, 5'(i), 6'(32 + i), 1, 6'(i));
    end
    cycles(3);
    check("b2b_rob_drained", robQ.size(), 32'd0);
    check("b2b_commitCount", commitCount, 32'd3);

    // Head not done for 4 cycles, then done.
    robQ.push_back(mk(0, 0, 0, 1, 5'd4, 6'h24, 6'd4, 32'h0));
    expectCommit(1, 5'd4, 6'h24, 1, 6'd4);
    cycles(4);
    check("notdone_no_pop", robQ.size(), 32'd1);
    tmpEntry = robQ[0];
    tmpEntry[ENTRY_W-1] = 1'b1;
    robQ[0] = tmpEntry;
    cycle();
    check("notdone_pop", robQ.size(), 32'd0);
    check("notdone_stallCount", stallCount, 32'd0);
    check("notdone_commitCount", commitCount, 32'd4);

    // Free list full blocks a regWrite head for 3 cycles.
    freeFull = 1'b1;
    robQ.push_back(mk(1, 0, 0, 1, 5'd5, 6'h25, 6'd5, 32'h0));
    expectCommit(1, 5'd5, 6'h25, 1, 6'd5);
    cycles(3);
    check("full_no_pop", robQ.size(), 32'd1);
    check("full_stallCount", stallCount, 32'd3);
    freeFull = 1'b0;
    cycle();
    check("full_release_pop", robQ.size(), 32'd0);
    check("full_commitCount", commitCount, 32'd5);

    // Free list full does not block a regWrite=0 head.
    freeFull = 1'b1;
    robQ.push_back(mk(1, 0, 0, 0, 5'd6, 6'h26, 6'd6, 32'h0));
    expectCommit(0, 5'd6, 6'h26, 0, 6'd6);
    cycle();
    check("full_nowrite_pop", robQ.size(), 32'd0);
    check("full_nowrite_stall", stallCount, 32'd3);
    freeFull = 1'b0;
    // Full with empty ROB counts no stall.
    freeFull = 1'b1;
    cycles(2);
    check("full_empty_stall", stallCount, 32'd3);
    freeFull = 1'b0;

    // Mispredict followed by two younger entries that must be flushed.
    robQ.push_back(mk(1, 1, 0, 1, 5'd7, 6'h27, 6'd7, 32'h0000_1000));
    expectCommit(1, 5'd7, 6'h27, 1, 6'd7);
    flushQ.push_back(32'h0000_1000);
    robQ.push_back(mk(1, 0, 0, 1, 5'd8, 6'h30, 6'd8, 32'h0));
    robQ.push_back(mk(1, 0, 0, 1, 5'd9, 6'h31, 6'd9, 32'h0));
    cycle();
    check("mis_pop", robQ.size(), 32'd2);
    check("mis_flush_N", 32'(lastFlush), 32'd0);
    cycle();
    check("mis_flush_N1", 32'(lastFlush), 32'd1);
    check("mis_rob_cleared", robQ.size(), 32'd0);
    cycle();
    check("mis_flush_N2", 32'(lastFlush), 32'd0);
    check("mis_commitCount", commitCount, 32'd7);

    // Halt with mispred and regWrite: pops without writes or flush.
    robQ.push_back(mk(1, 1, 1, 1, 5'd8, 6'h28, 6'd8, 32'h0000_2000));
    expectCommit(0, 5'd8, 6'h28, 0, 6'd8);
    robQ.push_back(mk(1, 0, 0, 1, 5'd9, 6'h29, 6'd9, 32'h0));
    robQ.push_back(mk(1, 0, 0, 1, 5'd10, 6'h2a, 6'd10, 32'h0));
    expectCommit(1, 5'd9, 6'h29, 1, 6'd9);
    expectCommit(1, 5'd10, 6'h2a, 1, 6'd10);
    cycle();
    check("halt_pop", robQ.size(), 32'd2);
    check("halt_halted_N1", 32'(halted), 32'd1);
    check("halt_commitCount", commitCount, 32'd8);
    cycles(3);
    check("halt_no_more_pops", robQ.size(), 32'd2);
    check("halt_still_halted", 32'(halted), 32'd1);
    check("halt_no_flush", 32'(lastFlush), 32'd0);
    reset = 1'b0;
    #1;
    check("halt_reset_clears", 32'(halted), 32'd0);
    check("halt_reset_count", commitCount, 32'd0);
    #1;
    reset = 1'b1;
    cycle();
    check("resume_first_pop", robQ.size(), 32'd1);
    cycle();
    check("resume_drained", robQ.size(), 32'd0);
    check("resume_commitCount", commitCount, 32'd2);

    // Commit counter wrap.
    dut.commitCountReg = 32'hFFFF_FFFF;
    robQ.push_back(mk(1, 0, 0, 1, 5'd11, 6'h2b, 6'd11, 32'h0));
    expectCommit(1, 5'd11, 6'h2b, 1, 6'd11);
    cycle();
    check("wrap_commitCount", commitCount, 32'd0);

    cycles(2);
    check("sb_commits_all_seen", expQ.size(), 32'd0);
    check("sb_flushes_all_seen", flushQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
